oam_dma_controller: RTL and testbench
=====================================

// Module: oam_dma_controller
// PURPOSE
//   Bus initiator for Game Boy OAM DMA. A CPU write to the DMA register (FF46) sets the source page.
//   The block then copies XFER_LEN bytes from {page,8'h00} to DEST_BASE, one byte per M-cycle.
//   It drives initiator-side addr/read_en/write_en/wdata toward the peripherals (cartridge, RAMs)
//   and samples their combinational rdata. dma_active tells the arbiter to lock the CPU out.
// PARAMETERS
//   XFER_LEN         160       bytes per transfer; legal range 1..256
//   DEST_BASE        16'hFE00  destination base address (OAM)
//   CYCLES_PER_BYTE  4         clk cycles per byte (T-cycles per M-cycle); must be >= 2
//   START_DELAY      1         idle byte-slots between the register write and the first byte
// PORTS
//   clk          in   1   system clock; all state changes on posedge
//   reset        in   1   synchronous reset, active-low (0 = reset)
//   reg_we       in   1   CPU write strobe, already decoded for FF46
//   reg_wdata    in   8   source page (high byte of the source address)
//   reg_rdata    out  8   last value written to FF46
//   bus_addr     out  16  initiator address
//   bus_read_en  out  1   read request this cycle
//   bus_write_en out  1   write request this cycle
//   bus_wdata    out  8   write data
//   bus_rdata    in   8   peripheral read data, valid combinationally in the same cycle as read_en
//   dma_active   out  1   high while in DELAY or XFER; arbiter blocks the CPU while high
//   dma_done     out  1   one-cycle pulse on the cycle the block re-enters IDLE after completing
// BEHAVIOUR
//   Reset values (reset=0 at posedge):
//     - state=IDLE, src_page=8'hFF, reg_rdata=8'hFF, idx=0, phase=0, data latch=0
//     - bus_read_en=0, bus_write_en=0, bus_addr=0, bus_wdata=0, dma_active=0, dma_done=0
//   Outputs:
//     - All outputs are decoded from registered state only; no input->output combinational path.
//     - Exception: bus_rdata is sampled into the latch.
//   State machine:
//     - IDLE: on reg_we, src_page<=reg_wdata, idx<=0, phase<=0, go to DELAY
//       (or straight to XFER if START_DELAY=0).
//     - DELAY: counts START_DELAY*CYCLES_PER_BYTE clks with the bus idle, then goes to XFER.
//     - XFER: phase counts 0..CYCLES_PER_BYTE-1 per byte.
//       - phase 0: bus_read_en=1, bus_addr={src_page,idx}; latch<=bus_rdata at posedge.
//       - phase 1: bus_write_en=1, bus_addr=DEST_BASE+idx, bus_wdata=latch.
//       - phases >=2: bus idle (read_en=write_en=0, addr=0).
//       - At phase CYCLES_PER_BYTE-1: if idx==XFER_LEN-1, go to IDLE with dma_done=1 next cycle;
//         else idx<=idx+1, phase<=0.
//   Arithmetic:
//     - idx is 8 bits, so the source never crosses its page.
//     - Destination is DEST_BASE + zero-extended idx, 16-bit, with no wrap handling needed.
//     - No source remapping: pages E0..FF are issued as-is; the decoder resolves them.
//   Latency and totals:
//     - Register write at posedge N -> dma_active=1 from cycle N+1.
//     - First read at N+1+START_DELAY*CYCLES_PER_BYTE.
//     - dma_active is high for exactly (START_DELAY+XFER_LEN)*CYCLES_PER_BYTE cycles.
//       Defaults: 644 clks, 160 reads, 160 writes.
//   Restart: reg_we while in DELAY or XFER aborts the transfer.
//     - Loads the new page, sets idx=0, phase=0, enters DELAY. dma_active stays high (no low gap).
//     - The bus access already driven in that cycle completes. No further accesses use the old page.
//   Simultaneous events:
//     - reg_we on the final phase of the last byte: the restart wins and dma_done is NOT pulsed.
//   Reset mid-transfer:
//     - Immediate return to reset values. The partial copy is not resumed.
//     - The next cycle drives read_en=write_en=0.
//   Invariants:
//     - read_en and write_en are never both high in one cycle.
//     - Exactly one read and one write per byte.
//   reg_rdata is readable at any time; it updates the cycle after reg_we.
// TESTING
//   1. Reset with reset=0 for 2 clks -> all outputs 0, reg_rdata=FF; no bus activity for 10 clks.
//   2. reg_we with C1, model returning addr[7:0]^8'h5A
//      -> reads C100..C19F and writes FE00..FE9F with matching data; 644 active clks; one dma_done.
//   3. Restart: write C1, then write D0 at byte idx 37
//      -> no reads from C125 onward; a full D000..D09F copy follows; one dma_done total.
//   4. Write 80 on the last byte's final phase -> no dma_done; a new 644-cycle transfer from 8000.
//   5. reset=0 during idx 100 phase 1 -> next cycle bus idle, dma_active=0; reg_rdata=FF.
//   6. CYCLES_PER_BYTE=2, START_DELAY=0, XFER_LEN=1
//      -> read at N+1, write FE00 at N+2, dma_done at N+3.

Source files
------------

// File: rtl/oam_dma_controller.sv
// OAM DMA bus initiator: a write to FF46 copies XFER_LEN bytes from {page,8'h00} to DEST_BASE.
// One byte per CYCLES_PER_BYTE clocks (read phase 0, write phase 1); all bus outputs decode from registered state.
module oam_dma_controller #(
  parameter int          XFER_LEN        = 160,
  parameter logic [15:0] DEST_BASE       = 16'hFE00,
  parameter int          CYCLES_PER_BYTE = 4,
  parameter int          START_DELAY     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reg_we,
  input  logic [7:0]  reg_wdata,
  output logic [7:0]  reg_rdata,
  output logic [15:0] bus_addr,
  output logic        bus_read_en,
  output logic        bus_write_en,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  output logic        dma_active,
  output logic        dma_done
);

  localparam int DELAY_CYC = START_DELAY * CYCLES_PER_BYTE;
  localparam int PW        = $clog2(CYCLES_PER_BYTE);
  localparam int DW        = (DELAY_CYC > 1) ? $clog2(DELAY_CYC) : 1;

  localparam logic [PW-1:0] PHASE_LAST = PW'(CYCLES_PER_BYTE - 1);
  localparam logic [PW-1:0] PHASE_RD   = PW'(0);
  localparam logic [PW-1:0] PHASE_WR   = PW'(1);
  localparam logic [DW-1:0] DELAY_LAST = DW'((DELAY_CYC > 0) ? DELAY_CYC - 1 : 0);
  localparam logic [7:0]    IDX_LAST   = 8'(XFER_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    XFER  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [7:0]    src_page, src_page_nxt;
  logic [7:0]    idx, idx_nxt;
  logic [PW-1:0] phase, phase_nxt;
  logic [DW-1:0] dly, dly_nxt;
  logic          done, done_nxt;
  logic [7:0]    latch;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      src_page <= 8'hFF;
      idx      <= 8'h00;
      phase    <= '0;
      dly      <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      src_page <= src_page_nxt;
      idx      <= idx_nxt;
      phase    <= phase_nxt;
      dly      <= dly_nxt;
      done     <= done_nxt;
    end
  end

  // Read data is captured on the edge that closes the read phase.
  always_ff @(posedge clk) begin
    if (!reset) begin
      latch <= 8'h00;
    end else if (bus_read_en) begin
      latch <= bus_rdata;
    end
  end

  always_comb begin
    state_nxt    = state;
    src_page_nxt = src_page;
    idx_nxt      = idx;
    phase_nxt    = phase;
    dly_nxt      = dly;
    done_nxt     = 1'b0;

    case (state)
      IDLE: begin
      end
      DELAY: begin
        if (dly == DELAY_LAST) begin
          state_nxt = XFER;
          dly_nxt   = '0;
        end else begin
          dly_nxt = dly + 1'b1;
        end
      end
      XFER: begin
        if (phase == PHASE_LAST) begin
          phase_nxt = '0;
          if (idx == IDX_LAST) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            idx_nxt = idx + 8'd1;
          end
        end else begin
          phase_nxt = phase + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A register write starts or restarts a transfer and overrides completion.
    if (reg_we) begin
      src_page_nxt = reg_wdata;
      idx_nxt      = 8'h00;
      phase_nxt    = '0;
      dly_nxt      = '0;
      done_nxt     = 1'b0;
      state_nxt    = (START_DELAY == 0) ? XFER : DELAY;
    end
  end

  always_comb begin
    bus_read_en  = (state == XFER) && (phase == PHASE_RD);
    bus_write_en = (state == XFER) && (phase == PHASE_WR);
    bus_addr     = 16'h0000;
    bus_wdata    = 8'h00;
    if (bus_read_en) begin
      bus_addr = {src_page, idx};
    end else if (bus_write_en) begin
      bus_addr  = DEST_BASE + {8'h00, idx};
      bus_wdata = latch;
    end
    dma_active = (state != IDLE);
    dma_done   = done;
    reg_rdata  = src_page;
  end

endmodule

// File: tb/tb_oam_dma_controller.sv
// Bench for oam_dma_controller: event-list reference model of whole transfers, restarts and resets.
module tb_oam_dma_controller;

  localparam int unsigned CPB  = 4;
  localparam int unsigned SD   = 1;
  localparam int unsigned LEN  = 160;
  localparam int unsigned TOT  = (SD + LEN) * CPB;
  localparam logic [15:0] DEST = 16'hFE00;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, reg_we, b_we;
  logic [7:0]  reg_wdata, b_wdata;
  logic [7:0]  reg_rdata, b_reg_rdata;
  logic [15:0] bus_addr, b_addr;
  logic        bus_read_en, bus_write_en, b_read_en, b_write_en;
  logic [7:0]  bus_wdata, b_wdata_o, bus_rdata, b_rdata;
  logic        dma_active, dma_done, b_active, b_done;

  assign bus_rdata = bus_addr[7:0] ^ 8'h5A;
  assign b_rdata   = b_addr[7:0] ^ 8'h5A;

  oam_dma_controller dut (
    .clk(clk), .reset(reset), .reg_we(reg_we), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .bus_addr(bus_addr), .bus_read_en(bus_read_en), .bus_write_en(bus_write_en),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .dma_active(dma_active), .dma_done(dma_done)
  );

  oam_dma_controller #(.XFER_LEN(1), .CYCLES_PER_BYTE(2), .START_DELAY(0)) dut_small (
    .clk(clk), .reset(reset), .reg_we(b_we), .reg_wdata(b_wdata), .reg_rdata(b_reg_rdata),
    .bus_addr(b_addr), .bus_read_en(b_read_en), .bus_write_en(b_write_en),
    .bus_wdata(b_wdata_o), .bus_rdata(b_rdata), .dma_active(b_active), .dma_done(b_done)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observed events: upper 32 bits hold the cycle number.
  logic [63:0] rd_q[$], wr_q[$], dn_q[$];
  logic [63:0] erd_q[$], ewr_q[$], edn_q[$];
  int act_cnt = 0;
  int overlap = 0;

  always @(negedge clk) begin
    if (bus_read_en && bus_write_en) overlap <= overlap + 1;
    if (bus_read_en)  rd_q.push_back({cyc, 16'h0000, bus_addr});
    if (bus_write_en) wr_q.push_back({cyc, 8'h00, bus_addr, bus_wdata});
    if (dma_done)     dn_q.push_back({cyc, 32'h0});
    if (dma_active)   act_cnt <= act_cnt + 1;
  end

  int          exp_act = 0;
  int unsigned act_end = 0;

  task automatic drop_after(input int unsigned w);
    logic [63:0] t;
    while (erd_q.size() > 0) begin t = erd_q[$]; if (t[63:32] > w) void'(erd_q.pop_back()); else break; end
    while (ewr_q.size() > 0) begin t = ewr_q[$]; if (t[63:32] > w) void'(ewr_q.pop_back()); else break; end
    while (edn_q.size() > 0) begin t = edn_q[$]; if (t[63:32] > w) void'(edn_q.pop_back()); else break; end
  endtask

  task automatic model_start(input logic [7:0] page, input int unsigned w);
    int unsigned rc;
    if (w <= act_end) begin
      drop_after(w);
      exp_act += int'(w + TOT - act_end);
    end else begin
      exp_act += int'(TOT);
    end
    act_end = w + TOT;
    for (int i = 0; i < int'(LEN); i++) begin
      rc = w + 1 + SD * CPB + int'(i) * CPB;
      erd_q.push_back({rc, 16'h0000, page, 8'(i)});
      ewr_q.push_back({rc + 1, 8'h00, DEST + 16'(i), 8'(i) ^ 8'h5A});
    end
    edn_q.push_back({w + TOT + 1, 32'h0});
  endtask

  task automatic model_reset(input int unsigned r);
    drop_after(r);
    if (r < act_end) begin
      exp_act -= int'(act_end - r);
      act_end = r;
    end
  endtask

  // Called on a negedge; the write is sampled on the following posedge.
  task automatic cpu_write(input logic [7:0] p);
    reg_we    = 1'b1;
    reg_wdata = p;
    model_start(p, cyc);
    @(negedge clk);
    reg_we = 1'b0;
    check("reg_rdata after write", reg_rdata, p);
  endtask

  task automatic wait_until(input int unsigned t);
    if (t > cyc) repeat (t - cyc) @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    model_reset(cyc);
    @(negedge clk);
    check("rst read_en", bus_read_en, 1'b0);
    check("rst write_en", bus_write_en, 1'b0);
    check("rst active", dma_active, 1'b0);
    check("rst reg_rdata", reg_rdata, 8'hFF);
    reset = 1'b1;
  endtask

  task automatic settle_and_compare(input string tag);
    int n;
    wait_until(act_end + 4);
    n = (rd_q.size() < erd_q.size()) ? rd_q.size() : erd_q.size();
    check({tag, " read count"}, rd_q.size(), erd_q.size());
    for (int i = 0; i < n; i++) check({tag, " read"}, rd_q[i], erd_q[i]);
    n = (wr_q.size() < ewr_q.size()) ? wr_q.size() : ewr_q.size();
    check({tag, " write count"}, wr_q.size(), ewr_q.size());
    for (int i = 0; i < n; i++) check({tag, " write"}, wr_q[i], ewr_q[i]);
    n = (dn_q.size() < edn_q.size()) ? dn_q.size() : edn_q.size();
    check({tag, " done count"}, dn_q.size(), edn_q.size());
    for (int i = 0; i < n; i++) check({tag, " done"}, dn_q[i], edn_q[i]);
    check({tag, " active cycles"}, act_cnt, exp_act);
    check({tag, " rd/wr overlap"}, overlap, 0);
    rd_q.delete(); wr_q.delete(); dn_q.delete();
    erd_q.delete(); ewr_q.delete(); edn_q.delete();
  endtask

  initial begin
    logic [7:0]  pg;
    int unsigned w, tgt;
    int          mode;

    reset = 1'b0; reg_we = 1'b0; reg_wdata = 8'h00; b_we = 1'b0; b_wdata = 8'h00;
    repeat (2) @(negedge clk);
    check("reset bus_addr", bus_addr, 16'h0000);
    check("reset read_en", bus_read_en, 1'b0);
    check("reset write_en", bus_write_en, 1'b0);
    check("reset wdata", bus_wdata, 8'h00);
    check("reset active", dma_active, 1'b0);
    check("reset done", dma_done, 1'b0);
    check("reset reg_rdata", reg_rdata, 8'hFF);
    check("reset small reg_rdata", b_reg_rdata, 8'hFF);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    settle_and_compare("idle");

    cpu_write(8'hC1);
    settle_and_compare("full C1");

    cpu_write(8'hC1);
    w = cyc - 1;
    wait_until(w + 1 + SD * CPB + 37 * CPB - 1);
    cpu_write(8'hD0);
    settle_and_compare("restart D0");

    cpu_write(8'h3C);
    wait_until(act_end);
    cpu_write(8'h80);
    settle_and_compare("last-phase restart");

    cpu_write(8'hC1);
    w = cyc - 1;
    wait_until(w + 1 + SD * CPB + 100 * CPB + 1);
    pulse_reset();
    settle_and_compare("mid reset");

    pg = 8'($urandom);
    b_we = 1'b1; b_wdata = pg;
    @(negedge clk);
    b_we = 1'b0;
    check("small read_en N+1", b_read_en, 1'b1);
    check("small read addr", b_addr, {pg, 8'h00});
    check("small active N+1", b_active, 1'b1);
    @(negedge clk);
    check("small write_en N+2", b_write_en, 1'b1);
    check("small write addr", b_addr, 16'hFE00);
    check("small wdata", b_wdata_o, 8'h5A);
    @(negedge clk);
    check("small done N+3", b_done, 1'b1);
    check("small active N+3", b_active, 1'b0);
    @(negedge clk);
    check("small done pulse width", b_done, 1'b0);

    for (int k = 0; k < 6; k++) begin
      pg   = 8'($urandom);
      mode = int'($urandom_range(0, 2));
      cpu_write(pg);
      w   = cyc - 1;
      tgt = w + 1 + $urandom_range(0, TOT - 1);
      if (mode == 1) begin
        wait_until(tgt);
        cpu_write(8'($urandom));
      end else if (mode == 2) begin
        wait_until(tgt);
        pulse_reset();
      end
      settle_and_compare($sformatf("random %0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
